// File: rtl/oam_dma_controller_pkg.sv
// Shared types and constants for the OAM DMA controller.
package oam_dma_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        WRITE,
        DONE
    } dma_state_t;

    // Contents of the 0xFF46 control write as seen by the controller.
    typedef struct packed {
        logic [7:0] page;
        logic       start;
    } control_reg_t;

    // One bus request toward the memory unit (from either owner).
    typedef struct packed {
        logic [15:0] address;
        logic        oe;
        logic        we;
        logic [7:0]  wdata;
    } bus_req_t;

    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
    localparam int          OAM_XFER_LEN  = 160;
    localparam logic [7:0]  ECHO_PAGE_LO  = 8'hE0;

    // Echo RAM pages 0xE0-0xFF alias work RAM 0xC0-0xDF.
    function automatic logic [7:0] remap_page(input logic [7:0] page);
        return (page >= ECHO_PAGE_LO) ? page - 8'h20 : page;
    endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// CPU-side, memory-side and status signals of the OAM DMA controller.
interface oam_dma_controller_if;
    logic        dma_start;
    logic [7:0]  dma_page;
    logic [15:0] cpu_address;
    logic        cpu_oe;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [15:0] mem_address;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        cpu_stall;
    logic        dma_active;
    logic        dma_done;

    // Controller side.
    modport slave (
        input  dma_start, dma_page, cpu_address, cpu_oe, cpu_we, cpu_wdata, mem_rdata,
        output mem_address, mem_oe, mem_we, mem_wdata, cpu_stall, dma_active, dma_done
    );

    // CPU / memory environment side.
    modport master (
        output dma_start, dma_page, cpu_address, cpu_oe, cpu_we, cpu_wdata, mem_rdata,
        input  mem_address, mem_oe, mem_we, mem_wdata, cpu_stall, dma_active, dma_done
    );
endinterface

// File: rtl/oam_dma_controller_bus_owner_mux.sv
// Selects which master (CPU or DMA engine) drives the memory port.
module bus_owner_mux
    import oam_dma_controller_pkg::*;
(
    input  bus_req_t cpu_req_i,
    input  bus_req_t dma_req_i,
    input  logic     dma_active_i,
    input  logic     bus_en_i,
    output bus_req_t mem_req_o
);

    // Owner select; strobes and data are forced low while the bus is disabled.
    always_comb begin
        // NOTE: every output gets a value before any condition so no latch is inferred.
        mem_req_o = dma_active_i ? dma_req_i : cpu_req_i;
        if (!bus_en_i) begin
            mem_req_o.oe    = 1'b0;
            mem_req_o.we    = 1'b0;
            mem_req_o.wdata = 8'h00;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies XFER_LEN bytes from {page, 8'h00} into OAM
// while stalling the CPU, then hands the memory port back.
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter logic [15:0] OAM_BASE     = OAM_BASE_ADDR,
    parameter int          XFER_LEN     = OAM_XFER_LEN,
    parameter int          SETUP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    oam_dma_controller_if.slave  bus_if
);

    localparam logic [7:0] LAST_IDX   = 8'(XFER_LEN - 1);
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

    dma_state_t   state_q;
    logic [7:0]   cnt_q;
    logic [7:0]   setup_cnt_q;
    logic [7:0]   page_q;
    logic [7:0]   latch_q;
    logic         active_q;
    logic         done_q;
    logic         oe_q;
    logic         we_q;
    control_reg_t ctrl;
    bus_req_t     cpu_req;
    bus_req_t     dma_req;
    bus_req_t     mem_req;

    assign ctrl = '{page: bus_if.dma_page, start: bus_if.dma_start};

    // Sequencer with registered strobes; a trigger in any state restarts from SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            setup_cnt_q <= '0;
            page_q      <= '0;
            latch_q     <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
        end else if (ctrl.start) begin
            state_q     <= SETUP;
            page_q      <= remap_page(ctrl.page);
            cnt_q       <= '0;
            setup_cnt_q <= '0;
            active_q    <= 1'b1;
            done_q      <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                SETUP: begin
                    if (setup_cnt_q == SETUP_LAST) begin
                        state_q <= READ;
                        oe_q    <= 1'b1;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 8'd1;
                    end
                end
                READ: begin
                    latch_q <= bus_if.mem_rdata;
                    oe_q    <= 1'b0;
                    we_q    <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    we_q  <= 1'b0;
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_q  <= DONE;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= READ;
                        oe_q    <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // DMA address: source byte in READ, OAM slot in WRITE.
    always_comb begin
        dma_req.address = (state_q == WRITE) ? (OAM_BASE + {8'h00, cnt_q}) : {page_q, cnt_q};
        dma_req.oe      = oe_q;
        dma_req.we      = we_q;
        dma_req.wdata   = latch_q;
    end

    assign cpu_req = '{address: bus_if.cpu_address, oe: bus_if.cpu_oe,
                       we: bus_if.cpu_we, wdata: bus_if.cpu_wdata};

    // rst_n gates the strobes so reset deasserts them without waiting for a clock.
    bus_owner_mux u_bus_owner_mux (
        .cpu_req_i    (cpu_req),
        .dma_req_i    (dma_req),
        .dma_active_i (active_q),
        .bus_en_i     (rst_n),
        .mem_req_o    (mem_req)
    );

    assign bus_if.mem_address = mem_req.address;
    assign bus_if.mem_oe      = mem_req.oe;
    assign bus_if.mem_we      = mem_req.we;
    assign bus_if.mem_wdata   = mem_req.wdata;
    assign bus_if.cpu_stall   = active_q;
    assign bus_if.dma_active  = active_q;
    assign bus_if.dma_done    = done_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: every expected memory write and
// dma_done pulse is queued with its cycle when stimulus is driven, and
// popped when the DUT produces it.
module tb_oam_dma_controller;
    import oam_dma_controller_pkg::*;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_vectors = 0;
    int   n_miscompares = 0;
    int   active_cnt = 0;
    int   viol_both = 0;
    int   viol_fea0 = 0;
    int   viol_stall = 0;
    wr_t  wr_q[$];
    int   done_q[$];
    logic [7:0] mem [0:65535];

    oam_dma_controller_if bus_if();

    oam_dma_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory unit model.
    assign bus_if.mem_rdata = bus_if.mem_oe ? mem[bus_if.mem_address] : 8'h00;
    always @(posedge clk) if (bus_if.mem_we) mem[bus_if.mem_address] <= bus_if.mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Source data patterns used for the preloaded regions.
    function automatic logic [7:0] pat(input logic [7:0] src, input logic [7:0] k);
        case (src)
            8'hC0:   return k ^ 8'h5A;
            8'hC1:   return 8'(k * 3 + 1);
            8'hD0:   return k ^ 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon
        wr_t e;
        int  d;
        if (bus_if.dma_active) active_cnt++;
        if (bus_if.mem_oe && bus_if.mem_we) viol_both++;
        if ((bus_if.mem_oe || bus_if.mem_we) && bus_if.mem_address == 16'hFEA0) viol_fea0++;
        if (bus_if.cpu_stall !== bus_if.dma_active) viol_stall++;
        if (bus_if.mem_we) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
                check("wr_addr", 32'(bus_if.mem_address), 32'(e.addr));
                check("wr_data", 32'(bus_if.mem_wdata), 32'(e.data));
            end
        end
        if (bus_if.dma_done) begin
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(d));
            end
        end
    end

    // Queue the OAM writes of a transfer triggered in cycle t.
    task automatic push_xfer(input logic [7:0] src, input int t, input int n);
        for (int k = 0; k < n; k++)
            wr_q.push_back('{cyc: t + 3 + 2 * k, addr: 16'hFE00 + 16'(k), data: pat(src, 8'(k))});
    endtask

    // Drive dma_start for one cycle; t returns the trigger cycle.
    task automatic pulse_start(input logic [7:0] page, output int t);
        bus_if.dma_start = 1'b1;
        bus_if.dma_page  = page;
        t = cyc;
        @(posedge clk); #1;
        bus_if.dma_start = 1'b0;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        bus_if.cpu_address = addr;
        bus_if.cpu_wdata   = data;
        bus_if.cpu_we      = 1'b1;
        wr_q.push_back('{cyc: cyc, addr: addr, data: data});
        @(posedge clk); #1;
        bus_if.cpu_we = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wr_q.size() == 0 && done_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_pending", 32'(wr_q.size() + done_q.size()), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_oam(input string tag, input logic [7:0] src);
        for (int k = 0; k < 160; k++)
            check(tag, 32'(mem[16'hFE00 + 16'(k)]), 32'(pat(src, 8'(k))));
    endtask

    initial begin : main
        int t, t2, a0;
        logic [7:0] pages [3];
        pages[0] = 8'hC0; pages[1] = 8'hC1; pages[2] = 8'hD0;

        // Reset, with a trigger and CPU strobes active: reset must win.
        rst_n              = 1'b0;
        bus_if.dma_start   = 1'b1;
        bus_if.dma_page    = 8'hC0;
        bus_if.cpu_address = 16'h1234;
        bus_if.cpu_oe      = 1'b1;
        bus_if.cpu_we      = 1'b1;
        bus_if.cpu_wdata   = 8'hAB;
        #8;
        check("rst_dma_active", 32'(bus_if.dma_active), 32'd0);
        check("rst_cpu_stall", 32'(bus_if.cpu_stall), 32'd0);
        check("rst_dma_done", 32'(bus_if.dma_done), 32'd0);
        check("rst_mem_oe", 32'(bus_if.mem_oe), 32'd0);
        check("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
        check("rst_mem_wdata", 32'(bus_if.mem_wdata), 32'd0);
        check("rst_mem_address", 32'(bus_if.mem_address), 32'h1234);
        #4;
        bus_if.dma_start = 1'b0;
        bus_if.cpu_oe    = 1'b0;
        bus_if.cpu_we    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(bus_if.dma_active), 32'd0);

        // Idle passthrough of a CPU read.
        bus_if.cpu_address = 16'hC005;
        bus_if.cpu_oe      = 1'b1;
        #1;
        check("pass_oe", 32'(bus_if.mem_oe), 32'd1);
        check("pass_addr", 32'(bus_if.mem_address), 32'hC005);
        bus_if.cpu_oe = 1'b0;
        @(posedge clk); #1;

        // Preload source regions through the idle passthrough.
        foreach (pages[p])
            for (int k = 0; k < 160; k++)
                cpu_write({pages[p], 8'(k)}, pat(pages[p], 8'(k)));
        drain(10);

        // Basic copy from page 0xC0.
        a0 = active_cnt;
        pulse_start(8'hC0, t);
        push_xfer(8'hC0, t, 160);
        done_q.push_back(t + 322);
        @(negedge clk);
        check("setup_active", 32'(bus_if.dma_active), 32'd1);
        check("setup_oe", 32'(bus_if.mem_oe), 32'd0);
        @(negedge clk);
        check("read0_oe", 32'(bus_if.mem_oe), 32'd1);
        check("read0_addr", 32'(bus_if.mem_address), 32'hC000);
        drain(400);
        check("active_cycles", 32'(active_cnt - a0), 32'd321);
        check_oam("oam_basic", 8'hC0);

        // Echo page 0xE1 reads from 0xC100.
        pulse_start(8'hE1, t);
        push_xfer(8'hC1, t, 160);
        done_q.push_back(t + 322);
        @(negedge clk);
        @(negedge clk);
        check("echo_read0_addr", 32'(bus_if.mem_address), 32'hC100);
        drain(400);
        check("echo_oam0", 32'(mem[16'hFE00]), 32'(pat(8'hC1, 8'd0)));
        check("echo_oam159", 32'(mem[16'hFE9F]), 32'(pat(8'hC1, 8'd159)));

        // Retrigger at offset 100 (a READ cycle): 49 bytes of the first copy land.
        pulse_start(8'hC0, t);
        push_xfer(8'hC0, t, 49);
        go_to(t + 100);
        pulse_start(8'hD0, t2);
        push_xfer(8'hD0, t2, 160);
        done_q.push_back(t2 + 322);
        @(negedge clk);
        check("retrig_setup_cycle", 32'(cyc), 32'(t + 101));
        check("retrig_setup_active", 32'(bus_if.dma_active), 32'd1);
        check("retrig_setup_we", 32'(bus_if.mem_we), 32'd0);
        drain(500);
        check_oam("oam_retrig", 8'hD0);

        // Asynchronous reset in the middle of cycle 150 (READ 74).
        pulse_start(8'hC0, t);
        push_xfer(8'hC0, t, 74);
        go_to(t + 150);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_oe", 32'(bus_if.mem_oe), 32'd0);
        check("midrst_mem_we", 32'(bus_if.mem_we), 32'd0);
        check("midrst_active", 32'(bus_if.dma_active), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_pending", 32'(wr_q.size()), 32'd0);
        pulse_start(8'hD0, t);
        push_xfer(8'hD0, t, 160);
        done_q.push_back(t + 322);
        drain(400);
        check_oam("oam_after_rst", 8'hD0);

        // CPU write to 0xC000 issued at cycle 50 of a transfer.
        pulse_start(8'hC0, t);
        push_xfer(8'hC0, t, 160);
        done_q.push_back(t + 322);
        go_to(t + 50);
        bus_if.cpu_address = 16'hC000;
        bus_if.cpu_wdata   = 8'h77;
        bus_if.cpu_we      = 1'b1;
        wr_q.push_back('{cyc: t + 322, addr: 16'hC000, data: 8'h77});
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus_if.cpu_stall) break;
        end
        check("stall_release_cycle", 32'(cyc), 32'(t + 322));
        check("cpu_wr_held", 32'(mem[16'hC000]), 32'h5A);
        @(posedge clk); #1;
        bus_if.cpu_we = 1'b0;
        check("cpu_wr_landed", 32'(mem[16'hC000]), 32'h77);
        drain(50);
        check_oam("oam_contention", 8'hC0);

        // Global properties.
        check("oe_we_both_high", 32'(viol_both), 32'd0);
        check("fea0_access", 32'(viol_fea0), 32'd0);
        check("stall_ne_active", 32'(viol_stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
